// File: rtl/route_sequencer.sv
// ---------------------------------------------------------------------------
// route_sequencer
//
// Queues station go-to commands arriving from the UART command register and
// hands them one at a time to the motion/station-tracking FSM.  Each trip is
// held until the motion FSM reports arrival, after which a dwell period is
// spent at the station before the next destination is offered.  Stop aborts
// the current trip and flushes the queue; clear-pending flushes only the
// queued entries.
//
// Parameters
//   DEPTH        : queue entries (power of 2, >= 2)
//   DWELL_CYCLES : cycles spent at a reached station (1..65535)
//
// Ports
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   cmd[7:0]     : command byte; cmd[7:6] = 01 go-to, 00 stop,
//                  10 clear-pending, 11 ignored; cmd[5:0] = station
//   cmd_rdy      : cmd valid
//   clr_cmd_rdy  : consumes the command (combinational, same cycle)
//   dest_ID[5:0] : head-of-queue station, meaningful while dest_vld
//   dest_vld     : dest_ID offered to the motion FSM
//   dest_ack     : motion FSM accepted dest_ID
//   arrived      : 1-cycle pulse, motion FSM reached the destination
//   stop_req     : 1-cycle pulse, abort the current trip
//   trip_active  : high while travelling
//   q_count      : queued entries (a trip already accepted is excluded)
//   overflow     : sticky, a go-to was dropped because the queue was full
//
// Build option
//   SEQ_DEDUP_EN : when defined, a go-to equal to the most recently enqueued
//                  destination is consumed and discarded.
// ---------------------------------------------------------------------------
module route_sequencer #(
   parameter int DEPTH        = 4,
   parameter int DWELL_CYCLES = 25000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               cmd,
   input  logic                     cmd_rdy,
   output logic                     clr_cmd_rdy,
   output logic [5:0]               dest_ID,
   output logic                     dest_vld,
   input  logic                     dest_ack,
   input  logic                     arrived,
   output logic                     stop_req,
   output logic                     trip_active,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     overflow
);

   localparam int          AW         = $clog2(DEPTH);
   localparam int          CW         = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_TRAVEL,
      S_DWELL
   } state_t;

   state_t           r_state;
   logic             r_dest_vld;
   logic             r_trip_active;
   logic             r_stop_req;
   logic [15:0]      r_dwell_cnt;

   logic [5:0]       r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;

   logic             w_goto;
   logic             w_stop;
   logic             w_clr;
   logic             w_full;
   logic             w_dup;
   logic             w_push;
   logic             w_drop;
   logic             w_pop;
   logic             w_flush;

   // ------------------------------------------------------------------------
   // Command decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_goto  = cmd_rdy && (cmd[7:6] == 2'b01);
      w_stop  = cmd_rdy && (cmd[7:6] == 2'b00);
      w_clr   = cmd_rdy && (cmd[7:6] == 2'b10);
      w_flush = w_stop || w_clr;
      // Fullness is judged before any same-cycle pop, so a pop never frees
      // a slot for the go-to arriving alongside it.
      w_full  = (r_count == FULL_CNT);
      w_push  = w_goto && !w_full && !w_dup;
      w_drop  = w_goto &&  w_full && !w_dup;
      // A stop in the same cycle as dest_ack wins: the handshake is discarded.
      w_pop   = (r_state == S_ISSUE) && dest_ack && !w_stop;
   end

`ifdef SEQ_DEDUP_EN
   // ------------------------------------------------------------------------
   // Last enqueued destination, used to discard repeated go-to commands
   // ------------------------------------------------------------------------
   logic [5:0] r_last_dest;
   logic       r_last_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_dest <= '0;
         r_last_vld  <= 1'b0;
      end else if (w_flush) begin
         r_last_vld  <= 1'b0;
      end else if (w_push) begin
         r_last_dest <= cmd[5:0];
         r_last_vld  <= 1'b1;
      end
   end

   assign w_dup = r_last_vld && (r_last_dest == cmd[5:0]);
`else
   assign w_dup = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Queue storage (no reset needed: entries are only read once counted)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= cmd[5:0];
      end
   end

   // ------------------------------------------------------------------------
   // Queue pointers, occupancy and overflow flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_flush) begin
            // A pop coinciding with clear-pending still hands the head to the
            // motion FSM; only the remaining entries are discarded.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end

         if (w_stop) begin
            r_overflow <= 1'b0;
         end else if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Trip sequencing FSM with registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_dest_vld    <= 1'b0;
         r_trip_active <= 1'b0;
         r_stop_req    <= 1'b0;
         r_dwell_cnt   <= '0;
      end else begin
         r_stop_req <= 1'b0;
         if (w_stop) begin
            r_state       <= S_IDLE;
            r_dest_vld    <= 1'b0;
            r_trip_active <= 1'b0;
            r_stop_req    <= 1'b1;
            r_dwell_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  // A clear-pending in this cycle empties the queue, so do
                  // not start offering an entry that is about to vanish.
                  if ((r_count != '0) && !w_clr) begin
                     r_state    <= S_ISSUE;
                     r_dest_vld <= 1'b1;
                  end
               end
               S_ISSUE: begin
                  if (dest_ack) begin
                     r_state       <= S_TRAVEL;
                     r_dest_vld    <= 1'b0;
                     r_trip_active <= 1'b1;
                  end else if (w_clr) begin
                     r_state    <= S_IDLE;
                     r_dest_vld <= 1'b0;
                  end
               end
               S_TRAVEL: begin
                  if (arrived) begin
                     r_state       <= S_DWELL;
                     r_trip_active <= 1'b0;
                     r_dwell_cnt   <= DWELL_LOAD;
                  end
               end
               S_DWELL: begin
                  if (r_dwell_cnt == '0) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_dwell_cnt <= r_dwell_cnt - 16'd1;
                  end
               end
               default: begin
                  r_state       <= S_IDLE;
                  r_dest_vld    <= 1'b0;
                  r_trip_active <= 1'b0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign clr_cmd_rdy = cmd_rdy & ~rst;
   assign dest_ID     = r_mem[r_rd_ptr];
   assign dest_vld    = r_dest_vld;
   assign trip_active = r_trip_active;
   assign stop_req    = r_stop_req;
   assign q_count     = r_count;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_route_sequencer.sv
module tb_route_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] cmd = 8'h00;
   logic       cmd_rdy = 1'b0;
   logic       clr_cmd_rdy;
   logic [5:0] dest_ID;
   logic       dest_vld;
   logic       dest_ack = 1'b0;
   logic       arrived = 1'b0;
   logic       stop_req;
   logic       trip_active;
   logic [2:0] q_count;
   logic       overflow;

   int errors = 0;
   int checks = 0;

   route_sequencer #(.DEPTH(4), .DWELL_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .dest_ID     (dest_ID),
      .dest_vld    (dest_vld),
      .dest_ack    (dest_ack),
      .arrived     (arrived),
      .stop_req    (stop_req),
      .trip_active (trip_active),
      .q_count     (q_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command for one cycle.
   task automatic send(input logic [7:0] b);
      cmd     = b;
      cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
   endtask

   // Wait up to max cycles for dest_vld.
   task automatic wait_vld(input int max, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         if (dest_vld) seen = 1'b1;
         else tick();
      end
      if (dest_vld) seen = 1'b1;
   endtask

   task automatic do_stop();
      send(8'h00);
      tick();
      tick();
   endtask

   task automatic test_reset();
      cmd = 8'h45; cmd_rdy = 1'b1; rst = 1'b1;
      tick(); tick();
      checks++; if (clr_cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_clr: got %0b exp 0", clr_cmd_rdy); end
      checks++; if (dest_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b exp 0", dest_vld); end
      checks++; if (trip_active !== 1'b0) begin errors++; $display("FAIL reset_trip: got %0b exp 0", trip_active); end
      checks++; if (stop_req !== 1'b0) begin errors++; $display("FAIL reset_stop: got %0b exp 0", stop_req); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_qcnt: got %0d exp 0", q_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b exp 0", overflow); end
      cmd_rdy = 1'b0;
      rst = 1'b0;
      tick(); tick(); tick();
      checks++; if (q_count !== 3'd0 || dest_vld !== 1'b0) begin errors++; $display("FAIL reset_release: got q=%0d vld=%0b exp q=0 vld=0", q_count, dest_vld); end
   endtask

   task automatic test_basic_trip();
      cmd = 8'h45; cmd_rdy = 1'b1;
      #1;
      checks++; if (clr_cmd_rdy !== 1'b1) begin errors++; $display("FAIL basic_clr: got %0b exp 1", clr_cmd_rdy); end
      tick(); cmd_rdy = 1'b0;                       // N+1
      checks++; if (q_count !== 3'd1 || dest_vld !== 1'b0) begin errors++; $display("FAIL basic_n1: got q=%0d vld=%0b exp q=1 vld=0", q_count, dest_vld); end
      tick();                                       // N+2
      checks++; if (dest_vld !== 1'b1 || dest_ID !== 6'd5) begin errors++; $display("FAIL basic_n2: got vld=%0b id=%0d exp vld=1 id=5", dest_vld, dest_ID); end
      tick();                                       // N+3, still offered
      checks++; if (dest_vld !== 1'b1) begin errors++; $display("FAIL basic_hold: got %0b exp 1", dest_vld); end
      dest_ack = 1'b1;
      tick(); dest_ack = 1'b0;                      // N+4
      checks++; if (dest_vld !== 1'b0 || trip_active !== 1'b1 || q_count !== 3'd0) begin errors++; $display("FAIL basic_ack: got vld=%0b trip=%0b q=%0d exp 0 1 0", dest_vld, trip_active, q_count); end
      send(8'h46);                                  // queue next trip during TRAVEL
      checks++; if (q_count !== 3'd1 || trip_active !== 1'b1) begin errors++; $display("FAIL basic_q2: got q=%0d trip=%0b exp q=1 trip=1", q_count, trip_active); end
      arrived = 1'b1;                               // cycle M
      tick(); arrived = 1'b0;                       // M+1
      checks++; if (trip_active !== 1'b0 || dest_vld !== 1'b0) begin errors++; $display("FAIL basic_arr: got trip=%0b vld=%0b exp 0 0", trip_active, dest_vld); end
      tick(); tick(); tick(); tick();               // M+5 (IDLE)
      checks++; if (dest_vld !== 1'b0) begin errors++; $display("FAIL basic_dwell: got vld=%0b exp 0 at M+5", dest_vld); end
      tick();                                       // M+6
      checks++; if (dest_vld !== 1'b1 || dest_ID !== 6'd6) begin errors++; $display("FAIL basic_next: got vld=%0b id=%0d exp vld=1 id=6", dest_vld, dest_ID); end
      do_stop();
   endtask

   task automatic test_overflow();
      bit seen;
      send(8'h41); send(8'h42); send(8'h43); send(8'h44); send(8'h45);
      checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL ovf_qcnt: got %0d exp 4", q_count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b exp 1", overflow); end
      for (int k = 1; k <= 4; k++) begin
         wait_vld(12, seen);
         checks++; if (!seen) begin errors++; $display("FAIL ovf_wait%0d: got no dest_vld exp dest_vld", k); end
         checks++; if (dest_ID !== 6'(k)) begin errors++; $display("FAIL ovf_order%0d: got %0d exp %0d", k, dest_ID, k); end
         dest_ack = 1'b1;
         tick(); dest_ack = 1'b0;
         checks++; if (q_count !== 3'(4 - k)) begin errors++; $display("FAIL ovf_pop%0d: got %0d exp %0d", k, q_count, 4 - k); end
         arrived = 1'b1;
         tick(); arrived = 1'b0;
      end
      wait_vld(12, seen);
      checks++; if (seen) begin errors++; $display("FAIL ovf_absent: got dest_vld id=%0d exp none", dest_ID); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b exp 1", overflow); end
   endtask

   task automatic test_stop();
      bit seen;
      send(8'h41);
      wait_vld(6, seen);
      dest_ack = 1'b1;
      tick(); dest_ack = 1'b0;
      send(8'h42); send(8'h43);
      checks++; if (q_count !== 3'd2 || trip_active !== 1'b1) begin errors++; $display("FAIL stop_pre: got q=%0d trip=%0b exp q=2 trip=1", q_count, trip_active); end
      send(8'h00);                                  // N+1
      checks++; if (stop_req !== 1'b1) begin errors++; $display("FAIL stop_pulse: got %0b exp 1", stop_req); end
      checks++; if (trip_active !== 1'b0 || dest_vld !== 1'b0) begin errors++; $display("FAIL stop_outs: got trip=%0b vld=%0b exp 0 0", trip_active, dest_vld); end
      checks++; if (q_count !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL stop_flush: got q=%0d ovf=%0b exp 0 0", q_count, overflow); end
      tick();
      checks++; if (stop_req !== 1'b0) begin errors++; $display("FAIL stop_width: got %0b exp 0", stop_req); end
      wait_vld(10, seen);
      checks++; if (seen) begin errors++; $display("FAIL stop_idle: got dest_vld exp none"); end
      send(8'h47);
      checks++; if (dest_vld !== 1'b0) begin errors++; $display("FAIL stop_go_n1: got %0b exp 0", dest_vld); end
      tick();
      checks++; if (dest_vld !== 1'b1 || dest_ID !== 6'd7) begin errors++; $display("FAIL stop_go_n2: got vld=%0b id=%0d exp vld=1 id=7", dest_vld, dest_ID); end
      do_stop();
   endtask

   task automatic test_back_to_back();
      bit seen;
      send(8'h41);
      wait_vld(6, seen);
      cmd = 8'h42; cmd_rdy = 1'b1; dest_ack = 1'b1;   // push and pop together
      tick(); cmd_rdy = 1'b0; dest_ack = 1'b0;
      checks++; if (q_count !== 3'd1 || trip_active !== 1'b1) begin errors++; $display("FAIL b2b_pushpop: got q=%0d trip=%0b exp q=1 trip=1", q_count, trip_active); end
      arrived = 1'b1;
      tick(); arrived = 1'b0;
      wait_vld(12, seen);
      checks++; if (!seen || dest_ID !== 6'd2) begin errors++; $display("FAIL b2b_head: got vld=%0b id=%0d exp vld=1 id=2", seen, dest_ID); end
      send(8'h43); send(8'h44); send(8'h45);
      checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL b2b_full: got %0d exp 4", q_count); end
      cmd = 8'h46; cmd_rdy = 1'b1; dest_ack = 1'b1;   // full + pop: still dropped
      tick(); cmd_rdy = 1'b0; dest_ack = 1'b0;
      checks++; if (q_count !== 3'd3 || overflow !== 1'b1) begin errors++; $display("FAIL b2b_fullpop: got q=%0d ovf=%0b exp q=3 ovf=1", q_count, overflow); end
      for (int k = 3; k <= 5; k++) begin
         arrived = 1'b1;
         tick(); arrived = 1'b0;
         wait_vld(12, seen);
         checks++; if (!seen || dest_ID !== 6'(k)) begin errors++; $display("FAIL b2b_order%0d: got vld=%0b id=%0d exp vld=1 id=%0d", k, seen, dest_ID, k); end
         dest_ack = 1'b1;
         tick(); dest_ack = 1'b0;
      end
      arrived = 1'b1;
      tick(); arrived = 1'b0;
      wait_vld(12, seen);
      checks++; if (seen) begin errors++; $display("FAIL b2b_dropped: got dest_vld id=%0d exp none", dest_ID); end
      do_stop();
   endtask

   task automatic test_stop_with_ack();
      bit seen;
      send(8'h41);
      wait_vld(6, seen);
      send(8'h42);
      cmd = 8'h00; cmd_rdy = 1'b1; dest_ack = 1'b1;
      tick(); cmd_rdy = 1'b0; dest_ack = 1'b0;
      checks++; if (stop_req !== 1'b1 || trip_active !== 1'b0 || dest_vld !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL stopack: got stop=%0b trip=%0b vld=%0b q=%0d exp 1 0 0 0", stop_req, trip_active, dest_vld, q_count); end
      wait_vld(10, seen);
      checks++; if (seen) begin errors++; $display("FAIL stopack_idle: got dest_vld exp none"); end
   endtask

   task automatic test_clear_pending();
      bit seen;
      // clear-pending together with dest_ack
      send(8'h41); send(8'h42); send(8'h43);
      checks++; if (q_count !== 3'd3 || dest_vld !== 1'b1) begin errors++; $display("FAIL clr_pre: got q=%0d vld=%0b exp q=3 vld=1", q_count, dest_vld); end
      cmd = 8'h80; cmd_rdy = 1'b1; dest_ack = 1'b1;
      tick(); cmd_rdy = 1'b0; dest_ack = 1'b0;
      checks++; if (trip_active !== 1'b1 || q_count !== 3'd0 || dest_vld !== 1'b0) begin errors++; $display("FAIL clr_ack: got trip=%0b q=%0d vld=%0b exp 1 0 0", trip_active, q_count, dest_vld); end
      arrived = 1'b1;
      tick(); arrived = 1'b0;
      wait_vld(12, seen);
      checks++; if (seen || trip_active !== 1'b0) begin errors++; $display("FAIL clr_ack_done: got vld=%0b trip=%0b exp 0 0", seen, trip_active); end
      // clear-pending in ISSUE without dest_ack
      send(8'h51); send(8'h52);
      wait_vld(6, seen);
      send(8'h80);
      checks++; if (dest_vld !== 1'b0 || q_count !== 3'd0 || trip_active !== 1'b0) begin errors++; $display("FAIL clr_noack: got vld=%0b q=%0d trip=%0b exp 0 0 0", dest_vld, q_count, trip_active); end
      wait_vld(10, seen);
      checks++; if (seen) begin errors++; $display("FAIL clr_noack_idle: got dest_vld exp none"); end
   endtask

   task automatic test_dedup();
      int clr_seen;
      int exp_q;
`ifdef SEQ_DEDUP_EN
      exp_q = 2;
`else
      exp_q = 3;
`endif
      clr_seen = 0;
      cmd = 8'h49; cmd_rdy = 1'b1; #1; if (clr_cmd_rdy) clr_seen++; tick();
      cmd = 8'h49; #1; if (clr_cmd_rdy) clr_seen++; tick();
      cmd = 8'h4A; #1; if (clr_cmd_rdy) clr_seen++; tick();
      cmd_rdy = 1'b0;
      checks++; if (clr_seen !== 3) begin errors++; $display("FAIL dedup_clr: got %0d pulses exp 3", clr_seen); end
      checks++; if (q_count !== 3'(exp_q)) begin errors++; $display("FAIL dedup_qcnt: got %0d exp %0d", q_count, exp_q); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dedup_ovf: got %0b exp 0", overflow); end
      do_stop();
   endtask

   task automatic test_reset_mid();
      bit seen;
      send(8'h41);
      wait_vld(6, seen);
      dest_ack = 1'b1;
      tick(); dest_ack = 1'b0;
      send(8'h42); send(8'h43); send(8'h44); send(8'h45); send(8'h46);
      checks++; if (q_count !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL rmid_pre: got q=%0d ovf=%0b exp q=4 ovf=1", q_count, overflow); end
      arrived = 1'b1;
      tick(); arrived = 1'b0;
      tick();                                       // inside DWELL
      cmd = 8'h11; cmd_rdy = 1'b1;
      #2 rst = 1'b1;
      #1;
      checks++; if (q_count !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rmid_async: got q=%0d ovf=%0b exp 0 0", q_count, overflow); end
      checks++; if (dest_vld !== 1'b0 || trip_active !== 1'b0 || stop_req !== 1'b0 || clr_cmd_rdy !== 1'b0) begin errors++; $display("FAIL rmid_outs: got vld=%0b trip=%0b stop=%0b clr=%0b exp 0 0 0 0", dest_vld, trip_active, stop_req, clr_cmd_rdy); end
      cmd_rdy = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      wait_vld(15, seen);
      checks++; if (seen || q_count !== 3'd0) begin errors++; $display("FAIL rmid_quiet: got vld=%0b q=%0d exp 0 0", seen, q_count); end
      send(8'h48);
      tick();
      checks++; if (dest_vld !== 1'b1 || dest_ID !== 6'd8) begin errors++; $display("FAIL rmid_go: got vld=%0b id=%0d exp vld=1 id=8", dest_vld, dest_ID); end
      do_stop();
   endtask

   initial begin
      test_reset();
      test_basic_trip();
      test_overflow();
      test_stop();
      test_back_to_back();
      test_stop_with_ack();
      test_clear_pending();
      test_dedup();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
